// File: rtl/multi_edge_detect_if.sv
// ---------------------------------------------------------------------------
// multi_edge_detect_if
//   Signal bundle between a multi-channel edge detector and its user.
//
//   level   [N]  raw asynchronous input levels           (master -> slave)
//   mode    [2]  global edge polarity select             (master -> slave)
//   en      [N]  per-channel tick/pending enable         (master -> slave)
//   clr     [N]  write-1-to-clear for pending            (master -> slave)
//   tick    [N]  one-clock pulse per accepted edge       (slave -> master)
//   pending [N]  sticky flag set by tick                 (slave -> master)
//   irq          OR of pending                           (slave -> master)
//
//   master : the control logic / bench that drives the inputs
//   slave  : the edge detector itself
// ---------------------------------------------------------------------------
interface multi_edge_detect_if #(
  parameter int N = 4
);
  logic [N-1:0] level;
  logic [1:0]   mode;
  logic [N-1:0] en;
  logic [N-1:0] clr;
  logic [N-1:0] tick;
  logic [N-1:0] pending;
  logic         irq;

  modport master (
    output level, mode, en, clr,
    input  tick, pending, irq
  );

  modport slave (
    input  level, mode, en, clr,
    output tick, pending, irq
  );
endinterface

// File: rtl/multi_edge_detect.sv
// ---------------------------------------------------------------------------
// multi_edge_detect
//   N-channel synchronised, glitch-filtered edge detector with a global,
//   selectable edge polarity. Each channel runs:
//     level -> synchroniser chain -> stable-count filter -> edge decode
//           -> registered tick + sticky pending (write-1-to-clear)
//   irq is the OR of all pending flags, registered alongside them.
//
// Parameters
//   N            number of independent channels (>=1)
//   SYNC_STAGES  synchroniser flops per channel (>=2)
//   FILT_CYCLES  consecutive cycles a new level must persist (>=1)
//
// Ports
//   clk    rising-edge system clock
//   reset  asynchronous, active-high reset
//   bus    slave side of multi_edge_detect_if:
//            level/mode/en/clr in, tick/pending/irq out
//
// Timing
//   A held level change produces its tick SYNC_STAGES + FILT_CYCLES + 1
//   clocks later. Mode and en are applied at the clock that registers the
//   tick, so a mode change takes effect from the next clock.
// ---------------------------------------------------------------------------
module multi_edge_detect #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  multi_edge_detect_if.slave bus
);

  localparam int                CNT_W    = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_mode_e;

  // Per-channel state
  logic [SYNC_STAGES-1:0] sync_ff  [N];
  logic [CNT_W-1:0]       filt_cnt [N];
  logic [N-1:0]           sync_lvl;
  logic [N-1:0]           stable;
  logic [N-1:0]           stable_d;

  // Output registers
  logic [N-1:0]           tick_q;
  logic [N-1:0]           pending_q;
  logic                   irq_q;

  // Decode
  edge_mode_e             mode_sel;
  logic [N-1:0]           rise;
  logic [N-1:0]           fall;
  logic [N-1:0]           qual;
  logic [N-1:0]           tick_next;
  logic [N-1:0]           pending_next;

  // -------------------------------------------------------------------------
  // Synchroniser: a pure shift chain, nothing between stages, so each stage
  // has a full clock period to resolve metastability.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain
  // into a single flop.
  // NOTE: the synchroniser flops are reset (not left free-running) so that
  // after reset the chain agrees with stable=0 and no phantom edge appears
  // from stale contents.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        sync_ff[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        sync_ff[i] <= {sync_ff[i][SYNC_STAGES-2:0], bus.level[i]};
      end
    end
  end

  // NOTE: every always_comb output gets a value on every path (defaults
  // first) so no latch is inferred.
  always_comb begin
    sync_lvl = '0;
    for (int i = 0; i < N; i++) begin
      sync_lvl[i] = sync_ff[i][SYNC_STAGES-1];
    end
  end

  // -------------------------------------------------------------------------
  // Stable-count filter: a new level is accepted only after it has differed
  // from the stable level for FILT_CYCLES consecutive clocks. Any return to
  // the stable level clears the count, so short glitches vanish entirely.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        filt_cnt[i] <= '0;
      end
      stable   <= '0;
      stable_d <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync_lvl[i] == stable[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == CNT_LAST) begin
          stable[i]   <= sync_lvl[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + CNT_W'(1);
        end
      end
      // One-clock-old copy of stable; a difference marks the flip.
      stable_d <= stable;
    end
  end

  // -------------------------------------------------------------------------
  // Edge decode and pending update. en only gates the outputs; the filter
  // above keeps tracking, so raising en later cannot fabricate an edge.
  // A clear and a set in the same clock leave pending set.
  // -------------------------------------------------------------------------
  assign mode_sel = edge_mode_e'(bus.mode);

  always_comb begin
    rise = stable & ~stable_d;
    fall = ~stable & stable_d;
    qual = '0;
    case (mode_sel)
      EDGE_RISE: qual = rise;
      EDGE_FALL: qual = fall;
      EDGE_BOTH: qual = rise | fall;
      default:   qual = '0;
    endcase
    tick_next    = qual & bus.en;
    pending_next = (pending_q & ~bus.clr) | tick_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      tick_q    <= tick_next;
      pending_q <= pending_next;
      // Built from the next-state pending so irq moves in the same clock.
      irq_q     <= |pending_next;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.pending = pending_q;
  assign bus.irq     = irq_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// ---------------------------------------------------------------------------
// tb_multi_edge_detect
//   Self-checking bench for multi_edge_detect at default parameters.
//   Directed table vectors and hand-written sequences cover latency, glitch
//   rejection, polarity modes, enable/clear interaction and reset. A
//   window-based reference model then checks a long random run.
// ---------------------------------------------------------------------------
module tb_multi_edge_detect;

  localparam int N           = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYCLES = 4;
  localparam int DEPTH       = SYNC_STAGES + FILT_CYCLES;
  localparam int LAT         = SYNC_STAGES + FILT_CYCLES + 1;

  logic clk;
  logic reset;

  multi_edge_detect_if #(.N(N)) bus ();

  multi_edge_detect #(
    .N           (N),
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: inputs are driven at a negedge, the DUT samples them at the
  // posedge, outputs are examined at the following negedge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_all();
    bus.clr = '1;
    cycle();
    bus.clr = '0;
  endtask

  // -------------------------------------------------------------------------
  // Reference model. A channel's accepted level flips when the last
  // FILT_CYCLES synchronised samples all disagree with it; a synchronised
  // sample is simply the raw level from SYNC_STAGES clocks earlier. The tick
  // for a flip appears one clock later, qualified by mode/en at that clock.
  // -------------------------------------------------------------------------
  logic [N-1:0] hist [$];
  logic [N-1:0] m_stable, m_rise, m_fall, m_tick, m_pend;
  logic         m_irq;

  function automatic logic [N-1:0] qualify(input logic [1:0] m,
                                           input logic [N-1:0] r,
                                           input logic [N-1:0] f);
    case (m)
      2'b00:   return r;
      2'b01:   return f;
      2'b10:   return r | f;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      for (int k = 0; k < DEPTH; k++) hist.push_back('0);
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_tick   = '0;
      m_pend   = '0;
      m_irq    = 1'b0;
    end else begin
      m_tick = qualify(bus.mode, m_rise, m_fall) & bus.en;
      m_pend = (m_pend & ~bus.clr) | m_tick;
      m_irq  = |m_pend;
      hist.push_front(bus.level);
      void'(hist.pop_back());
      m_rise = '0;
      m_fall = '0;
      for (int ch = 0; ch < N; ch++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = SYNC_STAGES; k < DEPTH; k++) begin
          if (hist[k][ch] == m_stable[ch]) all_diff = 1'b0;
        end
        if (all_diff) begin
          if (m_stable[ch]) m_fall[ch] = 1'b1;
          else              m_rise[ch] = 1'b1;
          m_stable[ch] = ~m_stable[ch];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed vector table: inputs held for 'reps' clocks, outputs compared
  // after every one of those clocks.
  // -------------------------------------------------------------------------
  typedef struct {
    string        name;
    logic [N-1:0] level;
    logic [1:0]   mode;
    logic [N-1:0] en;
    logic [N-1:0] clr;
    int           reps;
    logic [N-1:0] exp_tick;
    logic [N-1:0] exp_pend;
    logic         exp_irq;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input string nm, input logic [N-1:0] lv, input logic [N-1:0] cl,
                     input int reps, input logic [N-1:0] et, input logic [N-1:0] ep,
                     input logic ei);
    vec_t v;
    v.name = nm; v.level = lv; v.mode = 2'b00; v.en = '1; v.clr = cl;
    v.reps = reps; v.exp_tick = et; v.exp_pend = ep; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic edge_run(input int ch, input logic [1:0] m, input int high, input int total,
                          output int n, output int first, output int last);
    n = 0; first = -1; last = -1;
    bus.mode      = m;
    bus.level[ch] = 1'b1;
    for (int c = 1; c <= total; c++) begin
      if (c == high + 1) bus.level[ch] = 1'b0;
      cycle();
      if (bus.tick[ch]) begin
        n++;
        if (first < 0) first = c;
        last = c;
      end
    end
  endtask

  initial begin
    int n, first, last;

    reset     = 1'b1;
    bus.level = '0;
    bus.mode  = 2'b00;
    bus.en    = '1;
    bus.clr   = '0;

    // ---- 1: reset and idle --------------------------------------------
    repeat (3) @(negedge clk);
    check("rst_tick", bus.tick, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_irq", bus.irq, 0);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      check("idle_tick", bus.tick, 0);
      check("idle_pending", bus.pending, 0);
      check("idle_irq", bus.irq, 0);
    end

    // ---- 2/3 and simultaneous edges: table ---------------------------
    add("lat_wait",   4'b0001, 4'b0000, 6,  4'b0000, 4'b0000, 1'b0);
    add("lat_tick",   4'b0001, 4'b0000, 1,  4'b0001, 4'b0001, 1'b1);
    add("lat_hold",   4'b0001, 4'b0000, 2,  4'b0000, 4'b0001, 1'b1);
    add("lat_clr",    4'b0001, 4'b0001, 1,  4'b0000, 4'b0000, 1'b0);
    add("lat_idle",   4'b0001, 4'b0000, 2,  4'b0000, 4'b0000, 1'b0);
    add("glitch3_hi", 4'b0011, 4'b0000, 3,  4'b0000, 4'b0000, 1'b0);
    add("glitch3_lo", 4'b0001, 4'b0000, 10, 4'b0000, 4'b0000, 1'b0);
    add("pulse4_hi",  4'b0011, 4'b0000, 4,  4'b0000, 4'b0000, 1'b0);
    add("pulse4_lo",  4'b0001, 4'b0000, 2,  4'b0000, 4'b0000, 1'b0);
    add("pulse4_tick",4'b0001, 4'b0000, 1,  4'b0010, 4'b0010, 1'b1);
    add("pulse4_fall",4'b0001, 4'b0000, 8,  4'b0000, 4'b0010, 1'b1);
    add("pulse4_clr", 4'b0001, 4'b0010, 1,  4'b0000, 4'b0000, 1'b0);
    add("pulse4_idle",4'b0001, 4'b0000, 2,  4'b0000, 4'b0000, 1'b0);
    add("multi_wait", 4'b1111, 4'b0000, 6,  4'b0000, 4'b0000, 1'b0);
    add("multi_tick", 4'b1111, 4'b0000, 1,  4'b1110, 4'b1110, 1'b1);
    add("multi_clr",  4'b0001, 4'b1110, 1,  4'b0000, 4'b0000, 1'b0);
    add("multi_fall", 4'b0001, 4'b0000, 12, 4'b0000, 4'b0000, 1'b0);

    foreach (vecs[v]) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        bus.level = vecs[v].level;
        bus.mode  = vecs[v].mode;
        bus.en    = vecs[v].en;
        bus.clr   = vecs[v].clr;
        cycle();
        check({vecs[v].name, "_tick"}, bus.tick, vecs[v].exp_tick);
        check({vecs[v].name, "_pending"}, bus.pending, vecs[v].exp_pend);
        check({vecs[v].name, "_irq"}, bus.irq, vecs[v].exp_irq);
      end
    end
    bus.clr = '0;

    // ---- 4: polarity modes on channel 2 ------------------------------
    edge_run(2, 2'b10, 10, 25, n, first, last);
    check("both_count", n, 2);
    check("both_first", first, LAT);
    check("both_second", last, LAT + 10);
    check("both_pending", bus.pending[2], 1);
    clear_all();
    edge_run(2, 2'b01, 10, 25, n, first, last);
    check("fall_count", n, 1);
    check("fall_at", first, LAT + 10);
    clear_all();
    edge_run(2, 2'b11, 10, 25, n, first, last);
    check("none_count", n, 0);
    check("none_pending", bus.pending, 0);
    check("none_irq", bus.irq, 0);

    // ---- 5: clear/set collision, en masking on channel 3 -------------
    bus.mode     = 2'b00;
    bus.en       = '1;
    bus.level[3] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      bus.clr[3] = (c == LAT);
      cycle();
      if (c == LAT) begin
        check("setclr_tick", bus.tick[3], 1);
        check("setclr_pending", bus.pending[3], 1);
      end
      if (c == LAT + 1) begin
        check("setclr_hold_tick", bus.tick[3], 0);
        check("setclr_hold_pending", bus.pending[3], 1);
      end
    end
    bus.clr = '0;
    clear_all();
    check("en_pre_pending", bus.pending, 0);
    bus.en[3]    = 1'b0;
    bus.mode     = 2'b10;
    bus.level[3] = 1'b0;
    n = 0;
    repeat (12) begin
      cycle();
      if (bus.tick[3]) n++;
    end
    check("en_mask_ticks", n, 0);
    check("en_mask_pending", bus.pending[3], 0);
    bus.en[3] = 1'b1;
    n = 0;
    repeat (10) begin
      cycle();
      if (bus.tick[3]) n++;
    end
    check("en_raise_ticks", n, 0);
    bus.level[3] = 1'b1;
    first = -1;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (bus.tick[3] && first < 0) first = c;
    end
    check("en_track_rise_at", first, LAT);
    bus.level[3] = 1'b0;
    repeat (12) cycle();
    clear_all();

    // ---- 6: reset mid-count on channel 0 -----------------------------
    bus.level    = 4'b0001;
    bus.level[0] = 1'b0;
    repeat (10) cycle();
    check("pre_rst_pending", bus.pending[0], 1);
    bus.level[0] = 1'b1;
    repeat (3) cycle();
    reset = 1'b1;
    #1;
    check("midrst_tick", bus.tick, 0);
    check("midrst_pending", bus.pending, 0);
    check("midrst_irq", bus.irq, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      check("postrst_tick", bus.tick, (c == LAT) ? 4'b0001 : 4'b0000);
    end
    check("postrst_pending", bus.pending, 4'b0001);
    check("postrst_irq", bus.irq, 1);
    clear_all();

    // ---- random run against the reference model ----------------------
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(7) == 0) bus.level[ch] = ~bus.level[ch];
        if ($urandom_range(31) == 0) bus.en[ch] = ~bus.en[ch];
        bus.clr[ch] = ($urandom_range(7) == 0);
      end
      if ($urandom_range(63) == 0) bus.mode = 2'($urandom_range(3));
      if (cyc == 1500) reset = 1'b1;
      if (cyc == 1502) reset = 1'b0;
      cycle();
      check("rnd_tick", bus.tick, m_tick);
      check("rnd_pending", bus.pending, m_pend);
      check("rnd_irq", bus.irq, m_irq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
